// File: rtl/div_seq.sv
// Sequential 32-bit signed divider: restoring, one quotient bit per cycle.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W     = 32;
  localparam int unsigned CW    = 6;
  localparam int unsigned STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  mag_a, mag_a_d;
  logic [W-1:0]  mag_b, mag_b_d;
  logic          sign_q, sign_q_d;
  logic          sign_r, sign_r_d;
  logic [W-1:0]  rem, rem_d;
  logic [W-1:0]  quo, quo_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  hi_d, lo_d;
  logic          busy_d, done_d, div_zero_d;

  // Partial remainder after shifting in the next dividend bit. rem < |b| <= 2^31,
  // so the shifted value always fits in W bits.
  logic [W-1:0]  rem_sh;
  logic [W-1:0]  rem_sub;
  logic          rem_ge;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_d;
      mag_a    <= mag_a_d;
      mag_b    <= mag_b_d;
      sign_q   <= sign_q_d;
      sign_r   <= sign_r_d;
      rem      <= rem_d;
      quo      <= quo_d;
      cnt      <= cnt_d;
      hi       <= hi_d;
      lo       <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state;
    mag_a_d    = mag_a;
    mag_b_d    = mag_b;
    sign_q_d   = sign_q;
    sign_r_d   = sign_r;
    rem_d      = rem;
    quo_d      = quo;
    cnt_d      = cnt;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;
    div_zero_d = div_zero;

    rem_sh  = {rem[W-2:0], mag_a[W-1]};
    rem_sub = rem_sh - mag_b;
    rem_ge  = (rem_sh >= mag_b);

    case (state)
      IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
          if (b != '0) begin
            // -(2^31) wraps to 0x80000000, which is the correct unsigned magnitude
            mag_a_d  = a[W-1] ? W'(-a) : a;
            mag_b_d  = b[W-1] ? W'(-b) : b;
            sign_q_d = a[W-1] ^ b[W-1];
            sign_r_d = a[W-1];
            rem_d    = '0;
            quo_d    = '0;
            cnt_d    = '0;
            state_d  = CALC;
          end else begin
            state_d = ZERO;
          end
        end
      end
      CALC: begin
        mag_a_d = mag_a << 1;
        rem_d   = rem_ge ? rem_sub : rem_sh;
        quo_d   = {quo[W-2:0], rem_ge};
        cnt_d   = cnt + CW'(1);
        if (cnt == CW'(STEPS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sign_q ? W'(-quo) : quo;
        hi_d    = sign_r ? W'(-rem) : rem;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        div_zero_d = 1'b1;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  div_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit track);
    exp_t   e;
    longint sa, sb, q, r;
    a     = ta;
    b     = tb_;
    start = 1'b1;
    if (track) begin
      if (tb_ == 32'd0) begin
        e.lo  = last_lo;
        e.hi  = last_hi;
        e.dz  = 1'b1;
        e.cyc = cyc + 1 + 1;
      end else begin
        sa    = longint'($signed(ta));
        sb    = longint'($signed(tb_));
        q     = sa / sb;
        r     = sa % sb;
        e.lo  = q[31:0];
        e.hi  = r[31:0];
        e.dz  = 1'b0;
        e.cyc = cyc + 1 + 33;
        last_lo = e.lo;
        last_hi = e.hi;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; optionally scrambles inputs meanwhile.
  task automatic wait_done(input bit noisy);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noisy) begin
        start = 1'($urandom % 2);
        a     = $urandom;
        b     = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (cyc=%0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency_cyc", 32'(cyc), 32'(e.cyc));
        chk("busy_during_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] ta, tbv;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(32'd7, 32'd2, 1'b1);           wait_done(1'b0); @(negedge clk);
    issue(32'd5, 32'd0, 1'b1);           wait_done(1'b0); @(negedge clk);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);   wait_done(1'b0); @(negedge clk);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);   wait_done(1'b0); @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done(1'b0); @(negedge clk);

    // Asynchronous reset in the middle of a division
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    last_lo = '0;
    last_hi = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Back-to-back: second start presented during the done cycle
    issue(32'd100, 32'd7, 1'b1);
    wait_done(1'b0);
    issue(32'd9, 32'd3, 1'b1);
    wait_done(1'b1);
    @(negedge clk);

    // Randomized operations, some with input noise while busy
    for (int k = 0; k < 30; k++) begin
      ta = $urandom;
      case ($urandom % 8)
        0:       tbv = 32'd0;
        1:       tbv = ($urandom % 16) + 32'd1;
        2:       tbv = 32'hFFFF_FFFF;
        3:       tbv = 32'h8000_0000;
        default: tbv = $urandom;
      endcase
      if ($urandom % 6 == 0) ta = 32'h8000_0000;
      issue(ta, tbv, 1'b1);
      wait_done(k % 3 == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
